// File: rtl/ldpc_ber_counter_mc.sv
// rtl/ldpc_ber_counter_mc.sv - all-zero-codeword BER/block counter with 3-stage popcount pipeline
// Optional LDPC_BER_FER_EN adds per-block accumulation and frame-error counting.
module ldpc_ber_counter_mc #(
  parameter int DATA_WIDTH  = 128,
  parameter int CNT_WIDTH   = 64,
  parameter int LIMIT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  last_mask,
  input  logic [LIMIT_WIDTH-1:0] err_limit,
  input  logic [DATA_WIDTH-1:0]  s_axis_dout_tdata,
  input  logic                   s_axis_dout_tvalid,
  output logic                   s_axis_dout_tready,
  input  logic                   s_axis_dout_tlast,
  output logic [CNT_WIDTH-1:0]   bit_errors,
  output logic [CNT_WIDTH-1:0]   frame_errors,
  output logic [CNT_WIDTH-1:0]   blocks,
  output logic                   limit_hit,
  output logic                   busy
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int SUM_W = $clog2(DATA_WIDTH + 1);
  localparam int ACC_W = ((CNT_WIDTH > SUM_W) ? CNT_WIDTH : SUM_W) + 1;
  localparam int CMP_W = (CNT_WIDTH > LIMIT_WIDTH) ? CNT_WIDTH : LIMIT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STOP} state_t;

  state_t                state;
  logic                  mid_block;
  logic                  stop_pending;
  logic                  s1_valid, s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s2_valid, s2_last;
  logic [5:0]            s2_cnt   [LANES];
  logic [5:0]            lane_cnt [LANES];
  logic [SUM_W-1:0]      beat_sum;
  logic [ACC_W-1:0]      bit_sum;
  logic [CNT_WIDTH-1:0]  bit_next;
  logic                  accept, pipe_empty, hold_off;

  // Between blocks, a pending stop or a dropped enable closes the input before a new block starts.
  assign hold_off           = !mid_block && (stop_pending || !en);
  assign s_axis_dout_tready = (state == RUN) && !hold_off && !clear;
  assign accept             = s_axis_dout_tvalid && s_axis_dout_tready;
  assign pipe_empty         = !s1_valid && !s2_valid;
  assign busy               = (state != IDLE) || !pipe_empty;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_cnt[l] = '0;
      for (int b = 0; b < 32; b++)
        lane_cnt[l] = lane_cnt[l] + 6'(s1_data[l*32+b]);
    end
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum = beat_sum + SUM_W'(s2_cnt[l]);
    bit_sum  = ACC_W'(bit_errors) + ACC_W'(beat_sum);
    bit_next = (bit_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      for (int l = 0; l < LANES; l++) s2_cnt[l] <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= s_axis_dout_tlast ? (s_axis_dout_tdata & last_mask) : s_axis_dout_tdata;
        s1_last <= s_axis_dout_tlast;
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      for (int l = 0; l < LANES; l++) s2_cnt[l] <= lane_cnt[l];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_errors   <= '0;
      blocks       <= '0;
      stop_pending <= 1'b0;
    end else if (clear) begin
      bit_errors   <= '0;
      blocks       <= '0;
      stop_pending <= 1'b0;
    end else if (s2_valid) begin
      bit_errors <= bit_next;
      if (s2_last && blocks != CNT_MAX)
        blocks <= blocks + 1'b1;
      // Compare against the post-update total so DRAIN sees the stop as soon as the pipe empties.
      if (err_limit != '0 && CMP_W'(bit_next) >= CMP_W'(err_limit))
        stop_pending <= 1'b1;
    end
  end

`ifdef LDPC_BER_FER_EN
  logic [CNT_WIDTH-1:0] blk_errs;
  logic [ACC_W-1:0]     blk_sum;

  assign blk_sum = ACC_W'(blk_errs) + ACC_W'(beat_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_errs     <= '0;
      frame_errors <= '0;
    end else if (clear) begin
      blk_errs     <= '0;
      frame_errors <= '0;
    end else if (s2_valid) begin
      if (s2_last) begin
        blk_errs <= '0;
        if (blk_sum != '0 && frame_errors != CNT_MAX)
          frame_errors <= frame_errors + 1'b1;
      end else begin
        blk_errs <= (blk_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : blk_sum[CNT_WIDTH-1:0];
      end
    end
  end
`else
  assign frame_errors = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      limit_hit <= 1'b0;
      mid_block <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      limit_hit <= 1'b0;
      mid_block <= 1'b0;
    end else begin
      if (accept) mid_block <= !s_axis_dout_tlast;
      case (state)
        IDLE:  if (en && !limit_hit) state <= RUN;
        RUN: begin
          if (accept && s_axis_dout_tlast) begin
            if (!en || stop_pending) state <= DRAIN;
          end else if (hold_off) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            if (stop_pending) begin
              state     <= STOP;
              limit_hit <= 1'b1;
            end else if (en) begin
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: doc/ldpc_ber_counter_mc.md
LDPC_BER_COUNTER_MC -- requirements
Module: ldpc_ber_counter_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: dout beat width in bits, a multiple of 32.
REQ-002 SHALL have parameter CNT_WIDTH, default 64: width of the bit_errors, frame_errors and blocks counters.
REQ-003 SHALL have parameter LIMIT_WIDTH, default 32: width of err_limit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: run enable, sampled at block boundaries.
REQ-007 SHALL have port clear, input, 1 bit: synchronous pulse that zeroes statistics.
REQ-008 SHALL have port last_mask, input, DATA_WIDTH bits: valid-bit mask applied to tlast beats.
REQ-009 SHALL have port err_limit, input, LIMIT_WIDTH bits: bit-error stop threshold; 0 disables it.
REQ-010 SHALL have ports s_axis_dout_tdata (input, DATA_WIDTH), s_axis_dout_tvalid (input, 1), s_axis_dout_tready (output, 1) and s_axis_dout_tlast (input, 1): the decoded-data AXI4-Stream slave.
REQ-011 SHALL have outputs bit_errors, frame_errors and blocks, each CNT_WIDTH bits: the statistics counters.
REQ-012 SHALL have output limit_hit, 1 bit: stopped on the error threshold.
REQ-013 SHALL have output busy, 1 bit: high when the state is not IDLE or the pipeline is non-empty.

Function
REQ-014 The transmitted codeword SHALL be all-zero, so each 1 bit in the accepted tdata is one bit error; tlast beats SHALL be ANDed with last_mask before counting.
REQ-015 The counting pipeline SHALL be 3 stages: S1 registers the masked beat; S2 forms one popcount per 32-bit lane; S3 sums the lanes and accumulates. Counters SHALL update exactly 3 cycles after the beat is accepted.
REQ-016 The FSM SHALL have states IDLE (tready=0), RUN (tready=1), DRAIN (tready=0) and STOP (tready=0).
REQ-017 IDLE SHALL go to RUN when en=1 and limit_hit=0.
REQ-018 In RUN, an accepted tlast beat SHALL move the FSM to DRAIN if en=0 or stop_pending=1; otherwise the FSM SHALL stay in RUN.
REQ-019 In RUN, en falling mid-block SHALL NOT stop acceptance before that block's tlast beat.
REQ-020 When the pipeline is empty, DRAIN SHALL go to STOP if stop_pending=1, to RUN if en=1, and to IDLE otherwise.
REQ-021 stop_pending SHALL set when err_limit!=0 and bit_errors>=err_limit after an S3 update; entry to STOP SHALL set limit_hit.
REQ-022 STOP SHALL be left only by clear or reset.
REQ-023 blocks SHALL increment when a tlast beat reaches S3; bit_errors SHALL add the beat popcount.
REQ-024 All counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-025 The err_limit comparison SHALL zero-extend err_limit to CNT_WIDTH.
REQ-026 While clear=1 the block SHALL force tready=0, zero all counters, flush the pipeline, clear limit_hit and stop_pending, and go to IDLE; clear SHALL take priority over a same-cycle S3 update.
REQ-027 A beat with tvalid=1 and tready=0 SHALL NOT be counted; counting SHALL occur only on tvalid&&tready.

Reset
REQ-028 Reset SHALL clear the counters to 0, put the FSM in IDLE, clear the pipeline valids, and drive s_axis_dout_tready=0, limit_hit=0 and busy=0.
REQ-029 Reset asserted mid-block SHALL discard the partial block; the next accepted beat SHALL start a new block.

Configuration
REQ-030 When macro LDPC_BER_FER_EN is defined, a per-block error accumulator SHALL clear at each block start, and frame_errors SHALL increment when a tlast beat reaches S3 with a nonzero block total.
REQ-031 When LDPC_BER_FER_EN is undefined, frame_errors SHALL be constant 0 and no per-block accumulator SHALL be instantiated.

Verification (defaults, LDPC_BER_FER_EN defined)
REQ-032 Send en=1 and a 2-beat block: beat0 = 0xF, then a tlast beat of all ones with last_mask = 2^64-1. Three cycles after tlast: bit_errors=68, blocks=1, frame_errors=1.
REQ-033 Send an all-zero 3-beat block. Required: blocks increments by 1; bit_errors and frame_errors are unchanged.
REQ-034 Set err_limit=10 and send single-beat blocks of 8 ones each, separated by 5-cycle gaps. Required: after block 2, bit_errors=16, limit_hit=1, the FSM is in STOP, and tready stays 0 for 20 cycles.
REQ-035 Drop en=0 after beat 1 of a 4-beat block. Required: beats 2-4 are accepted, then DRAIN, then IDLE with tready=0 and blocks+1.
REQ-036 Pulse clear while a block is mid-pipeline. Required: all counters read 0 the next cycle, and the in-flight beat is not counted.
REQ-037 Set CNT_WIDTH=8 and send 3 tlast blocks of all ones with last_mask all ones. Required: bit_errors=255 (saturated) and blocks=3.
